// File: rtl/mtr_ctl_seq.sv
// mtr_ctl_seq: EBOX-side sequencer for the M8538 meter board.
// Host requests become SPEC MTR CTL / READ MTR sequences. Meter interrupts
// are serviced locally by a DS=7 vector read.
//
// Bit numbering follows the KL10 convention on the bus-facing fields:
//   REQ_OP bit 0 (command/read select) is the MSB, i.e. REQ_OP[3] here,
//   and REQ_OP[1:3] maps to REQ_OP[2:0].
//   EBUS[18] is bit 17 of the 18-bit vectors and EBUS[35] is bit 0, so
//   EBUS[20] is bit 15 and EBUS[21:22] are bits 14:13.
module mtr_ctl_seq #(
  parameter int SETUP_CYC = 1,
  parameter int READ_LAT  = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [3:0]  REQ_OP,
  input  logic [17:0] REQ_DATA,
  output logic        READY,
  output logic        DONE,
  output logic [17:0] RD_DATA,
  input  logic        EBOX_SYNC,
  output logic        SPEC_MTR_CTL,
  output logic [2:0]  MAGIC,
  output logic [2:0]  DIAG,
  output logic        READ_MTR,
  output logic        EBUS_DRIVE,
  output logic [17:0] EBUS_OUT,
  input  logic [17:0] EBUS_IN,
  input  logic        MTR_INTERRUPT_REQ,
  input  logic        INTR_EN,
  output logic        VEC_VALID,
  output logic        VEC_REQ,
  output logic [1:0]  VEC_SEL
);

  // A zero parameter still needs one cycle of setup / read settling.
  localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int READ_N  = (READ_LAT  < 1) ? 1 : READ_LAT;
  localparam int CNT_MAX = (SETUP_N > READ_N) ? SETUP_N : READ_N;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_N - 1);

  // Vector reads always use diagnostic select 7.
  localparam logic [2:0] DS_VECTOR = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAITSYNC,
    S_HOLD,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       magic_q, magic_d;
  logic [2:0]       diag_q, diag_d;
  logic [17:0]      ebus_q, ebus_d;
  logic [17:0]      rd_q, rd_d;
  logic             vec_op_q, vec_op_d;
  logic             done_q, done_d;
  logic             vvalid_q, vvalid_d;
  logic             vreq_q, vreq_d;
  logic [1:0]       vsel_q, vsel_d;

  // EBUS[18:19] carry nothing the meter returns that we keep.
  logic unused_ebus_hi;
  assign unused_ebus_hi = ^EBUS_IN[17:16];

  // State register and all latched fields; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      magic_q  <= '0;
      diag_q   <= '0;
      ebus_q   <= '0;
      rd_q     <= '0;
      vec_op_q <= 1'b0;
      done_q   <= 1'b0;
      vvalid_q <= 1'b0;
      vreq_q   <= 1'b0;
      vsel_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      magic_q  <= magic_d;
      diag_q   <= diag_d;
      ebus_q   <= ebus_d;
      rd_q     <= rd_d;
      vec_op_q <= vec_op_d;
      done_q   <= done_d;
      vvalid_q <= vvalid_d;
      vreq_q   <= vreq_d;
      vsel_q   <= vsel_d;
    end
  end

  // Next-state logic: request/interrupt arbitration, phase timing, capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    magic_d  = magic_q;
    diag_d   = diag_q;
    ebus_d   = ebus_q;
    rd_d     = rd_q;
    vec_op_d = vec_op_q;
    done_d   = 1'b0;
    vvalid_d = 1'b0;
    vreq_d   = vreq_q;
    vsel_d   = vsel_q;

    case (state_q)
      S_IDLE: begin
        // Host requests win over a pending interrupt; the interrupt is
        // looked at again on every idle cycle, including completion cycles.
        if (REQ) begin
          cnt_d = '0;
          if (REQ_OP[3]) begin
            magic_d = REQ_OP[2:0];
            ebus_d  = REQ_DATA;
            state_d = S_SETUP;
          end else begin
            diag_d   = REQ_OP[2:0];
            vec_op_d = 1'b0;
            state_d  = S_SETTLE;
          end
        end else if (INTR_EN && MTR_INTERRUPT_REQ) begin
          cnt_d    = '0;
          diag_d   = DS_VECTOR;
          vec_op_d = 1'b1;
          state_d  = S_SETTLE;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_WAITSYNC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The strobe itself is combinational; leave on the first sync cycle
      // so exactly one strobe cycle is produced.
      S_WAITSYNC: begin
        if (EBOX_SYNC) state_d = S_HOLD;
      end

      S_HOLD: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_SETTLE: begin
        if (cnt_q == READ_LAST) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        if (vec_op_q) begin
          vreq_d   = EBUS_IN[15];
          vsel_d   = EBUS_IN[14:13];
          vvalid_d = 1'b1;
        end else begin
          rd_d   = {2'b00, EBUS_IN[15:0]};
          done_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Phase-decoded bus controls; write data is only visible while driven.
  always_comb begin
    READY        = (state_q == S_IDLE);
    EBUS_DRIVE   = (state_q == S_SETUP) || (state_q == S_WAITSYNC) ||
                   (state_q == S_HOLD);
    READ_MTR     = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    SPEC_MTR_CTL = (state_q == S_WAITSYNC) && EBOX_SYNC;
    EBUS_OUT     = EBUS_DRIVE ? ebus_q : '0;
  end

  assign DONE      = done_q;
  assign VEC_VALID = vvalid_q;
  assign RD_DATA   = rd_q;
  assign MAGIC     = magic_q;
  assign DIAG      = diag_q;
  assign VEC_REQ   = vreq_q;
  assign VEC_SEL   = vsel_q;

endmodule
